// File: rtl/boreal_mem_pkg.sv
// Shared constants and request type for the Boreal SRAM arbiter slice.
package boreal_mem_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned TAG_W     = 1;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/boreal_rr_arb2.sv
// Stateless two-way round-robin selector; last=1 means port 1 won most recently.
module boreal_rr_arb2
    import boreal_mem_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last,
    output logic [NUM_PORTS-1:0] gnt
);

    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/boreal_sram_arb.sv
// Two-port round-robin arbiter in front of a single-cycle SRAM tile.
// Optional address range check enabled by defining BOREAL_ARB_RANGE_CHK_EN.
module boreal_sram_arb
    import boreal_mem_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [STRB_W-1:0] p0_req_wstrb,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    output logic              p0_resp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [STRB_W-1:0] p1_req_wstrb,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              p1_resp_err,
    output logic              m_req_valid,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic [STRB_W-1:0] m_req_wstrb,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_rdata,
    input  logic              m_resp_err,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic             last_q;
    logic [TAG_W-1:0] tag_q;
    logic             tag_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic                 accept;
    logic                 owner;
    logic                 oor;
    mem_req_t             sel;
    logic                 resp_any;
    logic [DATA_W-1:0]    resp_rdata;
    logic                 resp_err;

    // Gating with rst_n keeps grants low while reset is held.
    assign req = {p1_req_valid, p0_req_valid} & {NUM_PORTS{rst_n}};

    boreal_rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    assign p0_req_ready = gnt[0];
    assign p1_req_ready = gnt[1];
    assign accept       = |gnt;
    assign owner        = gnt[1];

    always_comb begin
        if (gnt[1]) begin
            sel = '{we: p1_req_we, addr: p1_req_addr, wdata: p1_req_wdata, wstrb: p1_req_wstrb};
        end else begin
            sel = '{we: p0_req_we, addr: p0_req_addr, wdata: p0_req_wdata, wstrb: p0_req_wstrb};
        end
    end

`ifdef BOREAL_ARB_RANGE_CHK_EN
    assign oor = ({2'b00, sel.addr[ADDR_W-1:2]} >= ADDR_W'(WORDS));
`else
    assign oor = 1'b0;
`endif

    assign m_req_valid = accept & ~oor;
    assign m_req_we    = sel.we;
    assign m_req_addr  = sel.addr;
    assign m_req_wdata = sel.wdata;
    assign m_req_wstrb = sel.wstrb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                last_q <= owner;
                tag_q  <= TAG_W'(owner);
            end
            tag_valid_q <= accept & ~oor;
            err_q       <= accept & oor;
            if (p0_req_valid && p1_req_valid && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign conflict_cnt = cnt_q;

    // A local range error replaces the tile response for that cycle.
    always_comb begin
        resp_any   = (tag_valid_q & m_resp_valid) | err_q;
        resp_rdata = err_q ? '0 : m_resp_rdata;
        resp_err   = err_q | m_resp_err;

        p0_resp_valid = resp_any & (tag_q == TAG_W'(0));
        p1_resp_valid = resp_any & (tag_q == TAG_W'(1));
        p0_resp_rdata = p0_resp_valid ? resp_rdata : '0;
        p1_resp_rdata = p1_resp_valid ? resp_rdata : '0;
        p0_resp_err   = p0_resp_valid & resp_err;
        p1_resp_err   = p1_resp_valid & resp_err;
    end

endmodule

// File: tb/tb_boreal_sram_arb.sv
// Scoreboard bench for boreal_sram_arb with a behavioural single-cycle SRAM tile.
module tb_boreal_sram_arb;

    localparam int unsigned WORDS = 1024;
`ifdef BOREAL_ARB_RANGE_CHK_EN
    localparam bit RangeChk = 1'b1;
`else
    localparam bit RangeChk = 1'b0;
`endif

    typedef struct {
        bit          valid;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tb_req_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        p0_req_valid = 0, p0_req_we = 0, p1_req_valid = 0, p1_req_we = 0;
    logic [31:0] p0_req_addr = '0, p0_req_wdata = '0, p1_req_addr = '0, p1_req_wdata = '0;
    logic [3:0]  p0_req_wstrb = '0, p1_req_wstrb = '0;
    logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
    logic [31:0] p0_resp_rdata, p1_resp_rdata;
    logic        m_req_valid, m_req_we;
    logic [31:0] m_req_addr, m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_resp_valid = 1'b0;
    logic [31:0] m_resp_rdata = '0;
    logic        m_resp_err = 1'b0;
    logic [15:0] conflict_cnt;

    logic        s_p0_req_ready, s_p1_req_ready, s_p0_resp_valid, s_p1_resp_valid;
    logic        s_p0_resp_err, s_p1_resp_err, s_m_req_valid, s_m_req_we;
    logic [31:0] s_p0_resp_rdata, s_p1_resp_rdata, s_m_req_addr, s_m_req_wdata;
    logic [3:0]  s_m_req_wstrb;
    logic [3:0]  s_conflict_cnt;

    boreal_sram_arb #(.WORDS(WORDS), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .m_req_valid(m_req_valid), .m_req_we(m_req_we), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
        .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    boreal_sram_arb #(.WORDS(WORDS), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(s_p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
        .p0_resp_valid(s_p0_resp_valid), .p0_resp_rdata(s_p0_resp_rdata),
        .p0_resp_err(s_p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(s_p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
        .p1_resp_valid(s_p1_resp_valid), .p1_resp_rdata(s_p1_resp_rdata),
        .p1_resp_err(s_p1_resp_err),
        .m_req_valid(s_m_req_valid), .m_req_we(s_m_req_we), .m_req_addr(s_m_req_addr),
        .m_req_wdata(s_m_req_wdata), .m_req_wstrb(s_m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
        .conflict_cnt(s_conflict_cnt)
    );

    // SRAM tile: index truncated to 10 bits, reads return data next cycle, writes return 0.
    logic [31:0] tile_mem [WORDS];
    always @(posedge clk) begin
        m_resp_valid <= m_req_valid;
        m_resp_err   <= 1'b0;
        m_resp_rdata <= '0;
        if (m_req_valid) begin
            if (m_req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_req_wstrb[b]) tile_mem[m_req_addr[11:2]][8*b +: 8] <= m_req_wdata[8*b +: 8];
                end
            end else begin
                m_resp_rdata <= tile_mem[m_req_addr[11:2]];
            end
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    bit          tb_last = 1'b1;
    int          exp_conf = 0;
    logic [31:0] ref_mem [WORDS];
    exp_resp_t   exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic tb_req_t rd(input logic [31:0] addr);
        tb_req_t r = '{valid: 1'b1, we: 1'b0, addr: addr, wdata: '0, wstrb: '0};
        return r;
    endfunction

    function automatic tb_req_t wr(input logic [31:0] addr, input logic [31:0] d,
                                   input logic [3:0] s);
        tb_req_t r = '{valid: 1'b1, we: 1'b1, addr: addr, wdata: d, wstrb: s};
        return r;
    endfunction

    function automatic tb_req_t idle();
        tb_req_t r = '{valid: 1'b0, we: 1'b0, addr: '0, wdata: '0, wstrb: '0};
        return r;
    endfunction

    task automatic drive(input tb_req_t r0, input tb_req_t r1);
        p0_req_valid = r0.valid; p0_req_we = r0.we; p0_req_addr = r0.addr;
        p0_req_wdata = r0.wdata; p0_req_wstrb = r0.wstrb;
        p1_req_valid = r1.valid; p1_req_we = r1.we; p1_req_addr = r1.addr;
        p1_req_wdata = r1.wdata; p1_req_wstrb = r1.wstrb;
    endtask

    task automatic check_resp();
        exp_resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("resp_valid_own", e.port ? p1_resp_valid : p0_resp_valid, 1);
            check_eq("resp_valid_other", e.port ? p0_resp_valid : p1_resp_valid, 0);
            check_eq("resp_rdata", e.port ? p1_resp_rdata : p0_resp_rdata, e.rdata);
            check_eq("resp_err", e.port ? p1_resp_err : p0_resp_err, e.err);
        end else begin
            check_eq("resp_idle_valid", {p1_resp_valid, p0_resp_valid}, 0);
            check_eq("resp_idle_rdata", p0_resp_rdata | p1_resp_rdata, 0);
            check_eq("resp_idle_err", {p1_resp_err, p0_resp_err}, 0);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input tb_req_t r0, input tb_req_t r1);
        tb_req_t w;
        bit      g0, g1, oor;
        int      idx;
        check_resp();
        check_eq("conflict_cnt", 32'(conflict_cnt), exp_conf);
        check_eq("conflict_cnt_sat", 32'(s_conflict_cnt), exp_conf > 15 ? 15 : exp_conf);
        drive(r0, r1);
        #1;
        g0 = r0.valid && (!r1.valid || tb_last);
        g1 = r1.valid && (!r0.valid || !tb_last);
        check_eq("p0_req_ready", p0_req_ready, g0);
        check_eq("p1_req_ready", p1_req_ready, g1);
        if (g0 || g1) begin
            w       = g1 ? r1 : r0;
            tb_last = g1;
            oor     = RangeChk && (w.addr[31:2] >= WORDS);
            check_eq("m_req_valid", m_req_valid, !oor);
            if (oor) begin
                exp_q.push_back('{port: g1, rdata: '0, err: 1'b1});
            end else begin
                check_eq("m_req_addr", m_req_addr, w.addr);
                check_eq("m_req_we", m_req_we, w.we);
                idx = int'(w.addr[31:2]) % WORDS;
                if (w.we) begin
                    check_eq("m_req_wdata", m_req_wdata, w.wdata);
                    check_eq("m_req_wstrb", m_req_wstrb, w.wstrb);
                    for (int b = 0; b < 4; b++) begin
                        if (w.wstrb[b]) ref_mem[idx][8*b +: 8] = w.wdata[8*b +: 8];
                    end
                    exp_q.push_back('{port: g1, rdata: '0, err: 1'b0});
                end else begin
                    exp_q.push_back('{port: g1, rdata: ref_mem[idx], err: 1'b0});
                end
            end
        end else begin
            check_eq("m_req_valid_idle", m_req_valid, 0);
        end
        if (r0.valid && r1.valid) exp_conf++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        tb_last  = 1'b1;
        exp_conf = 0;
    endtask

    // Requests are held valid during reset to show the grants stay low.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive(rd(32'h0), rd(32'h4));
        #1;
        check_eq("rst_ready", {p1_req_ready, p0_req_ready}, 0);
        check_eq("rst_m_req_valid", m_req_valid, 0);
        check_eq("rst_resp_valid", {p1_resp_valid, p0_resp_valid}, 0);
        repeat (2) @(negedge clk);
        check_eq("rst_conflict_cnt", 32'(conflict_cnt), 0);
        model_reset();
        drive(idle(), idle());
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            tile_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        @(negedge clk);
        apply_reset();

        // p0-only write then read back
        step(wr(32'h10, 32'hDEADBEEF, 4'hF), idle());
        step(rd(32'h10), idle());
        step(idle(), idle());

        // Alternating grants under sustained conflict
        apply_reset();
        for (int i = 0; i < 4; i++) step(rd(32'h40 + 32'(i*8)), rd(32'h44 + 32'(i*8)));
        step(idle(), idle());
        check_eq("conflict_after_4", 32'(conflict_cnt), 4);

        // Partial-strobe write merges over the prior value
        step(idle(), wr(32'h20, 32'hFFFFFFFF, 4'hF));
        step(idle(), wr(32'h20, 32'h11223344, 4'h3));
        step(rd(32'h20), idle());
        check_eq("merge_rdata", p0_resp_rdata, 32'hFFFF3344);
        step(idle(), idle());

        // Address beyond the tile depth
        step(rd(32'h1000), idle());
        step(idle(), idle());

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            tb_req_t r[2];
            for (int p = 0; p < 2; p++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 15) * 4)
                                                : 32'($urandom_range(0, 63) * 4);
                if ($urandom_range(0, 3) == 0) r[p] = idle();
                else if ($urandom_range(0, 1) == 0) r[p] = wr(a, $urandom, 4'($urandom));
                else r[p] = rd(a);
            end
            step(r[0], r[1]);
        end
        step(idle(), idle());

        // Saturation of the narrow counter
        apply_reset();
        for (int i = 0; i < 20; i++) step(rd(32'h8), rd(32'hC));
        step(idle(), idle());
        check_eq("sat_at_15", 32'(s_conflict_cnt), 15);

        // Asynchronous reset with a response in flight
        drive(rd(32'h10), idle());
        #1;
        check_eq("pre_rst_ready", p0_req_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_ready", p0_req_ready, 0);
        check_eq("async_rst_m_req_valid", m_req_valid, 0);
        check_eq("async_rst_resp_valid", {p1_resp_valid, p0_resp_valid}, 0);
        @(negedge clk);
        drive(idle(), idle());
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(rd(32'h10), rd(32'h14));
        step(idle(), idle());
        step(idle(), idle());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
